// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch responder: reads 4 bytes from byte-wide RAM and assembles a little-endian word.
// Latency: ready pulses 5 cycles after acceptance (1-cycle RAM read latency, one byte per cycle).
// Backpressure: rdy=0 freezes all state and outputs; a jump aborts and restarts any fetch in flight.
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              pc_enable_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_enable_i,
  input  logic [7:0]        mem_din_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  output logic              pc_plus4_ready_o,
  output logic              inst_ready_o,
  output logic [INST_W-1:0] inst_o,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        buf0;
  logic [7:0]        buf1;
  logic [7:0]        buf2;
  logic [2:0]        next_off;
  logic [ADDR_W-1:0] next_addr;

  // Offset of the next byte to address; wraps naturally modulo 2^ADDR_W.
  always_comb begin
    next_off  = cnt + 3'd1;
    next_addr = addr + {{(ADDR_W-3){1'b0}}, next_off};
  end

  assign mem_wr_o = 1'b0;
  assign busy_o   = (state != S_IDLE);

  // Fetch sequencer: accept, step through 4 byte reads, pulse completion for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= 3'd0;
      addr             <= '0;
      mem_a_o          <= '0;
      buf0             <= 8'd0;
      buf1             <= 8'd0;
      buf2             <= 8'd0;
      inst_o           <= '0;
      pc_plus4_ready_o <= 1'b0;
      inst_ready_o     <= 1'b0;
    end else if (rdy) begin
      // Pulses are single-cycle unless a completion re-asserts them below.
      pc_plus4_ready_o <= 1'b0;
      inst_ready_o     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pc_enable_i || jump_enable_i) begin
            addr    <= pc_i;
            mem_a_o <= pc_i;
            cnt     <= 3'd0;
            state   <= S_FETCH;
          end
        end
        S_DONE: begin
          // pc_i still holds the old PC here, so only a redirect may start a fetch.
          if (jump_enable_i) begin
            addr    <= pc_i;
            mem_a_o <= pc_i;
            cnt     <= 3'd0;
            state   <= S_FETCH;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (jump_enable_i) begin
            // Redirect wins over everything, including the completion edge.
            addr    <= pc_i;
            mem_a_o <= pc_i;
            cnt     <= 3'd0;
          end else begin
            case (cnt)
              3'd1:    buf0 <= mem_din_i;
              3'd2:    buf1 <= mem_din_i;
              3'd3:    buf2 <= mem_din_i;
              default: ;
            endcase
            if (cnt <= 3'd2) begin
              mem_a_o <= next_addr;
            end
            cnt <= next_off;
            if (cnt == 3'd4) begin
              inst_o           <= {mem_din_i, buf2, buf1, buf0};
              pc_plus4_ready_o <= 1'b1;
              inst_ready_o     <= 1'b1;
              state            <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed vector table, hand-written corner sequences, random run.
// A transaction-level model predicts outputs every cycle; the RAM model honours rdy stalls.
// Vectors are applied at the falling edge and checked at the following falling edge.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        pc_enable;
  logic [31:0] pc_in;
  logic        jump_enable;
  logic [7:0]  mem_din = 8'd0;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        p4_rdy;
  logic        i_rdy;
  logic [31:0] inst;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.ADDR_W(32), .INST_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .pc_enable_i      (pc_enable),
    .pc_i             (pc_in),
    .jump_enable_i    (jump_enable),
    .mem_din_i        (mem_din),
    .mem_a_o          (mem_a),
    .mem_wr_o         (mem_wr),
    .pc_plus4_ready_o (p4_rdy),
    .inst_ready_o     (i_rdy),
    .inst_o           (inst),
    .busy_o           (busy)
  );

  // RAM contents: fixed program words at 0x100 and 0x200, an address checksum elsewhere.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'hA0;
      32'h103: return 8'h00;
      32'h200: return 8'h6F;
      32'h201: return 8'h00;
      32'h202: return 8'h00;
      32'h203: return 8'h00;
      default: return a[7:0] + a[15:8] + a[23:16] + a[31:24];
    endcase
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {ram_byte(a + 32'd3), ram_byte(a + 32'd2), ram_byte(a + 32'd1), ram_byte(a)};
  endfunction

  // Byte-wide RAM with one cycle of read latency, stalled by the same rdy.
  always @(posedge clk) begin
    if (rdy) mem_din <= ram_byte(mem_a);
  end

  // Reference model: 0 idle, 1 fetching, 2 completion cycle.
  int          m_phase = 0;
  int          m_el    = 0;
  logic [31:0] m_addr  = 32'd0;
  logic [31:0] m_mem_a = 32'd0;
  logic [31:0] m_inst  = 32'd0;
  logic        m_pulse = 1'b0;

  task automatic m_start(input logic [31:0] p);
    m_phase = 1;
    m_el    = 0;
    m_addr  = p;
    m_mem_a = p;
    m_pulse = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic y, input logic pe, input logic j,
                            input logic [31:0] p);
    if (r) begin
      m_phase = 0; m_el = 0; m_addr = 0; m_mem_a = 0; m_inst = 0; m_pulse = 1'b0;
    end else if (y) begin
      case (m_phase)
        1: begin
          if (j) m_start(p);
          else begin
            m_el++;
            m_mem_a = m_addr + 32'((m_el < 3) ? m_el : 3);
            if (m_el == 5) begin
              m_inst  = ram_word(m_addr);
              m_pulse = 1'b1;
              m_phase = 2;
            end
          end
        end
        2: begin
          m_pulse = 1'b0;
          if (j) m_start(p);
          else m_phase = 0;
        end
        default: begin
          m_pulse = 1'b0;
          if (pe || j) m_start(p);
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance DUT and model on the rising edge, compare at the falling edge.
  task automatic step(input logic r, input logic y, input logic pe, input logic j,
                      input logic [31:0] p);
    rst = r; rdy = y; pc_enable = pe; jump_enable = j; pc_in = p;
    @(posedge clk);
    model_edge(r, y, pe, j, p);
    @(negedge clk);
    chk("model_mem_a", mem_a, m_mem_a);
    chk("model_inst", inst, m_inst);
    chk("model_inst_ready", {31'd0, i_rdy}, {31'd0, m_pulse});
    chk("model_pc_plus4_ready", {31'd0, p4_rdy}, {31'd0, m_pulse});
    chk("model_busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
    chk("mem_wr", {31'd0, mem_wr}, 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  typedef struct {
    logic        rst, rdy, pe, j;
    logic [31:0] pc;
    logic [31:0] e_mem_a;
    logic        e_pulse;
    logic [31:0] e_inst;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic pe, input logic j, input logic [31:0] p,
                              input logic [31:0] ea, input logic ep, input logic [31:0] ei,
                              input logic eb);
    vec_t v;
    v.rst = r; v.rdy = 1'b1; v.pe = pe; v.j = j; v.pc = p;
    v.e_mem_a = ea; v.e_pulse = ep; v.e_inst = ei; v.e_busy = eb;
    return v;
  endfunction

  vec_t vt[25];

  initial begin
    rst = 1'b1; rdy = 1'b1; pc_enable = 1'b0; jump_enable = 1'b0; pc_in = 32'd0;

    // Reset, basic fetch at 0x100 with pc_enable held, back-to-back fetch at 0x104,
    // then a redirect to 0x200 while a fetch at 0x100 sits at cnt==2.
    vt[0]  = mk(1, 0, 0, 32'h000, 32'h000, 0, 32'h00000000, 0);
    vt[1]  = mk(0, 1, 0, 32'h100, 32'h100, 0, 32'h00000000, 1);
    vt[2]  = mk(0, 1, 0, 32'h100, 32'h101, 0, 32'h00000000, 1);
    vt[3]  = mk(0, 1, 0, 32'h100, 32'h102, 0, 32'h00000000, 1);
    vt[4]  = mk(0, 1, 0, 32'h100, 32'h103, 0, 32'h00000000, 1);
    vt[5]  = mk(0, 1, 0, 32'h100, 32'h103, 0, 32'h00000000, 1);
    vt[6]  = mk(0, 1, 0, 32'h100, 32'h103, 1, 32'h00A00513, 1);
    vt[7]  = mk(0, 1, 0, 32'h104, 32'h103, 0, 32'h00A00513, 0);
    vt[8]  = mk(0, 1, 0, 32'h104, 32'h104, 0, 32'h00A00513, 1);
    vt[9]  = mk(0, 1, 0, 32'h104, 32'h105, 0, 32'h00A00513, 1);
    vt[10] = mk(0, 1, 0, 32'h104, 32'h106, 0, 32'h00A00513, 1);
    vt[11] = mk(0, 1, 0, 32'h104, 32'h107, 0, 32'h00A00513, 1);
    vt[12] = mk(0, 1, 0, 32'h104, 32'h107, 0, 32'h00A00513, 1);
    vt[13] = mk(0, 1, 0, 32'h104, 32'h107, 1, 32'h08070605, 1);
    vt[14] = mk(0, 0, 0, 32'h108, 32'h107, 0, 32'h08070605, 0);
    vt[15] = mk(0, 1, 0, 32'h100, 32'h100, 0, 32'h08070605, 1);
    vt[16] = mk(0, 0, 0, 32'h100, 32'h101, 0, 32'h08070605, 1);
    vt[17] = mk(0, 0, 0, 32'h100, 32'h102, 0, 32'h08070605, 1);
    vt[18] = mk(0, 0, 1, 32'h200, 32'h200, 0, 32'h08070605, 1);
    vt[19] = mk(0, 0, 0, 32'h000, 32'h201, 0, 32'h08070605, 1);
    vt[20] = mk(0, 0, 0, 32'h000, 32'h202, 0, 32'h08070605, 1);
    vt[21] = mk(0, 0, 0, 32'h000, 32'h203, 0, 32'h08070605, 1);
    vt[22] = mk(0, 0, 0, 32'h000, 32'h203, 0, 32'h08070605, 1);
    vt[23] = mk(0, 0, 0, 32'h000, 32'h203, 1, 32'h0000006F, 1);
    vt[24] = mk(0, 0, 0, 32'h000, 32'h203, 0, 32'h0000006F, 0);

    for (int i = 0; i < 25; i++) begin
      step(vt[i].rst, vt[i].rdy, vt[i].pe, vt[i].j, vt[i].pc);
      chk($sformatf("tbl%0d_mem_a", i), mem_a, vt[i].e_mem_a);
      chk($sformatf("tbl%0d_inst", i), inst, vt[i].e_inst);
      chk($sformatf("tbl%0d_inst_ready", i), {31'd0, i_rdy}, {31'd0, vt[i].e_pulse});
      chk($sformatf("tbl%0d_pc_plus4_ready", i), {31'd0, p4_rdy}, {31'd0, vt[i].e_pulse});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].e_busy});
    end

    // Jump on the completion edge: old result kept, no pulse, target completes 5 cycles later.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h300);
    for (int i = 0; i < 4; i++) idle();
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h104);
    chk("cj_no_pulse", {31'd0, i_rdy}, 32'd0);
    chk("cj_inst_kept", inst, 32'h0000006F);
    chk("cj_mem_a", mem_a, 32'h104);
    for (int i = 0; i < 4; i++) idle();
    chk("cj_not_early", {31'd0, i_rdy}, 32'd0);
    idle();
    chk("cj_pulse", {31'd0, i_rdy}, 32'd1);
    chk("cj_inst", inst, 32'h08070605);
    idle();

    // rdy low for 3 cycles at cnt==1: everything frozen, pulse 3 cycles late.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
    idle();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("stall_mem_a", mem_a, 32'h101);
      chk("stall_no_pulse", {31'd0, p4_rdy}, 32'd0);
    end
    for (int i = 0; i < 3; i++) idle();
    chk("stall_not_early", {31'd0, p4_rdy}, 32'd0);
    idle();
    chk("stall_pulse", {31'd0, p4_rdy}, 32'd1);
    chk("stall_inst", inst, 32'h00A00513);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall_pulse_held", {31'd0, i_rdy}, 32'd1);
    idle();
    chk("stall_pulse_drop", {31'd0, i_rdy}, 32'd0);

    // Reset at cnt==3 discards the fetch.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
    for (int i = 0; i < 3; i++) idle();
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pulse", {31'd0, i_rdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("rst_no_late_pulse", {31'd0, i_rdy}, 32'd0);
    end

    // Address wrap across 2^32.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
    chk("wrap_a0", mem_a, 32'hFFFF_FFFE);
    idle(); chk("wrap_a1", mem_a, 32'hFFFF_FFFF);
    idle(); chk("wrap_a2", mem_a, 32'h0000_0000);
    idle(); chk("wrap_a3", mem_a, 32'h0000_0001);
    idle();
    idle();
    chk("wrap_pulse", {31'd0, i_rdy}, 32'd1);
    chk("wrap_inst", inst, 32'h0100FCFB);
    idle();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic r, y, pe, j;
      r  = ($urandom_range(0, 59) == 0);
      y  = r ? 1'b1 : ($urandom_range(0, 6) != 0);
      pe = $urandom_range(0, 1) == 1;
      j  = ($urandom_range(0, 11) == 0);
      step(r, y, pe, j, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Instruction-fetch side of the memory controller; the responder to the PC register's fetch request.
- Accepts a PC request or a jump redirect and reads 4 bytes from the byte-wide unified RAM (1-cycle read latency).
- Assembles a little-endian 32-bit instruction and returns it to IF with single-cycle ready pulses.
- The pulses tell the PC register when to advance (pc+4) or when a redirect is still legal.

Parameters:
- ADDR_W, 32, address width of PC and RAM address.
- INST_W, 32, instruction width; fixed at 4 bytes.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global ready; low freezes all state and outputs.
- pc_enable_i  input  1  PC register requests a fetch at pc_i.
- pc_i  input  ADDR_W  fetch address from the PC register.
- jump_enable_i  input  1  redirect pulse; pc_i carries the jump target in the same cycle.
- mem_din_i  input  8  RAM read data; valid the cycle after its address is driven.
- mem_a_o  output  ADDR_W  RAM byte address, registered.
- mem_wr_o  output  1  RAM write strobe; always 0 in this block.
- pc_plus4_ready_o  output  1  one-cycle pulse: fetch complete, PC may advance.
- inst_ready_o  output  1  one-cycle pulse: inst_o valid.
- inst_o  output  INST_W  assembled instruction; holds its value until the next completion.
- busy_o  output  1  fetch in flight (state != IDLE).

Behaviour:
- Reset, synchronous, rst=1 at posedge:
  - state=IDLE, cnt=0.
  - mem_a_o, inst_o and the latched address are 0.
  - pc_plus4_ready_o, inst_ready_o and busy_o are 0.
  - Reset mid-fetch discards the partial instruction; no ready pulse is produced.
- rdy=0: no register changes (state, cnt, buffer, outputs all hold). The RAM is stalled by the same rdy.
- States: IDLE, FETCH, DONE.
- IDLE:
  - Accept when pc_enable_i=1 or jump_enable_i=1: addr<=pc_i, mem_a_o<=pc_i, cnt<=0, state<=FETCH.
- FETCH, evaluated at each posedge:
  - If cnt>=1: byte[cnt-1]<=mem_din_i.
  - If cnt<=2: mem_a_o<=addr+cnt+1.
  - cnt<=cnt+1.
  - At cnt==4: capture byte3, inst_o<={byte3,byte2,byte1,byte0}, pulse pc_plus4_ready_o and inst_ready_o, state<=DONE.
- Latency:
  - Acceptance at edge E0; bytes captured at E2..E5.
  - Both ready pulses are high in the cycle following E5, i.e. 5 cycles after acceptance.
- DONE:
  - Single turnaround cycle; both ready pulses are high here. state<=IDLE.
  - pc_enable_i is ignored here, so the stale PC is never refetched.
  - jump_enable_i in DONE is accepted as in IDLE.
- Redirect (jump_enable_i=1) while in FETCH:
  - Abort the current fetch; no ready pulses.
  - Restart immediately: addr<=pc_i, mem_a_o<=pc_i, cnt<=0, stay in FETCH.
  - If the jump coincides with the cnt==4 edge, the jump wins: inst_o keeps its old value and no pulse is produced.
- Address arithmetic wraps modulo 2^ADDR_W; for example, pc 0xFFFF_FFFE reads FFFE, FFFF, 0000, 0001.
- pc_plus4_ready_o and inst_ready_o are never high for more than one cycle, except when held by rdy=0.

Test Plan:
- Basic fetch:
  - Stimulus: reset, then pc_enable_i=1 with pc_i=0x100; RAM[0x100..0x103] = 13 05 A0 00.
  - Required: mem_a_o sequence 0x100, 0x101, 0x102, 0x103; inst_o=0x00A00513; both pulses exactly 5 cycles after acceptance, one cycle wide.
- Back-to-back fetches:
  - Stimulus: pc_enable_i held high; the PC register advances pc_i to 0x104 on the pulse.
  - Required: no re-accept of 0x100 during DONE; the next fetch starts at 0x104 one cycle later.
- Mid-fetch redirect:
  - Stimulus: jump_enable_i with pc_i=0x200 at cnt==2 of a fetch at 0x100.
  - Required: no pulse for 0x100; mem_a_o=0x200 next cycle; RAM[0x200..] = 6F 00 00 00 gives inst_o=0x0000006F.
- Redirect on the completion edge:
  - Stimulus: jump coincident with the cnt==4 edge.
  - Required: inst_ready_o stays 0, inst_o unchanged, and the fetch at the target completes 5 cycles later.
- rdy stall:
  - Stimulus: rdy=0 for 3 cycles at cnt==1.
  - Required: mem_a_o, cnt and outputs frozen; the result is still correct, and the pulse is delayed by exactly 3 cycles.
- Reset and wrap:
  - Stimulus: rst=1 at cnt==3.
  - Required: all outputs 0 next cycle with no pulse.
  - Then fetch pc_i=0xFFFFFFFE: mem_a_o sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
